axichannel_log_buffer: RTL and testbench
========================================

# axichannel_log_buffer

Storage-side buffer directly downstream of the per-channel logger's pipelined logging outputs. It captures the begin-of-transaction log stream (valid-only, no ready) into a FIFO and counts end-of-transaction pulses. It drives both almost-full back-pressure signals with thresholds sized for the logger's register-pipeline round trip. It re-emits begins and ends as two ready/valid streams toward the log merger, preserving the begin-before-end order.

## Interface
Parameters:
- DATA_WIDTH, 32, begin-record payload width
- DEPTH, 64, begin FIFO entries; power of 2; must satisfy DEPTH > 2*PIPE_DEPTH+2
- PIPE_DEPTH, 4, logger register-pipeline stages (same value as the upstream logger)
- CNT_WIDTH, 16, pending-end counter width

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- logb_valid  in  1  begin record arrives; no ready, must be accepted
- logb_data  in  DATA_WIDTH  begin payload
- loge_valid  in  1  one end event; never stalled
- logb_almful  out  1  registered; feeds the logger's pipelined almful path
- logb_almful_imme  out  1  registered; feeds the logger's direct almful input
- out_valid / out_ready / out_data  out/in/out  1/1/DATA_WIDTH  begin stream to merger
- eout_valid / eout_ready  out/in  1/1  end stream to merger
- err_overflow  out  1  sticky; begin dropped or end counter saturated

## Operation
- Begin FIFO: circular RAM with rd_ptr/wr_ptr, log2(DEPTH)+1 bits each (wrap bit distinguishes full from empty); count = wr_ptr - rd_ptr.
- Write on logb_valid when not full. If logb_valid arrives while full, drop the record, set err_overflow, and leave the pointers unchanged.
- Read: out_valid is high when an output register holds data (first-word-fall-through). The output register refills from RAM on the same edge that out_ready pops it.
- Simultaneous write and read while full: the read frees a slot, so the write is accepted. Simultaneous write and read while empty: data bypasses into the output register.
- Thresholds use count_next, the count after this cycle's push/pop:
  - logb_almful <= (count_next >= DEPTH-(2*PIPE_DEPTH+2))
  - logb_almful_imme <= (count_next >= DEPTH-(PIPE_DEPTH+2))
- Pending-end counter pend_e (CNT_WIDTH bits):
  - +1 on loge_valid, -1 on an eout handshake; both in the same cycle leaves it unchanged.
  - Saturates at all-ones. A loge_valid at saturation sets err_overflow and is lost.
- Begin-before-end ordering: counter emitted_gap (CNT_WIDTH bits) = begins handshaked on out minus ends handshaked on eout.
  - eout_valid = (pend_e != 0) && (emitted_gap != 0 || out handshake this cycle is not required).
  - Concretely: eout_valid = (pend_e != 0) && (emitted_gap != 0). An end is never offered before its begin has left.
- err_overflow clears only on rst.

## Timing
- Reset values: out_valid=0, eout_valid=0, logb_almful=0, logb_almful_imme=0, err_overflow=0, all pointers and counters 0, out_data=0.
- Latency from logb_valid to out_valid is 1 cycle when empty (registered bypass).
- Latency from loge_valid to eout_valid is 1 cycle, provided a matching begin has already been emitted.
- Both almful flags update 1 cycle after the triggering push.
- Once logb_almful_imme asserts, at most PIPE_DEPTH+1 further begins can arrive. Once logb_almful asserts, at most 2*PIPE_DEPTH+1 can arrive. No drop occurs in legal operation.
- Ready/valid rules: out_valid/out_data and eout_valid stay stable until their ready is seen; ready may toggle freely.
- Asynchronous rst mid-stream discards all buffered records and pending ends immediately; outputs return to reset values without waiting for a clock edge.

## Configuration
- AXICHANNEL_LOG_BUFFER_STATS_EN defined: adds outputs stat_begins (32b), stat_ends (32b) and stat_max_occ (log2(DEPTH)+1 bits).
  - stat_begins and stat_ends count accepted begins and ends, wrapping at 2^32.
  - stat_max_occ records the peak FIFO count.
  - All three are reset to 0 by rst.
- Undefined: these ports and their logic are absent; behaviour is otherwise identical.

## Test plan
- Reset with logb_valid held high during rst -> all outputs 0, nothing stored; first write after rst deasserts yields out_valid on the next cycle with that payload.
- Begins 0..9 on consecutive cycles with out_ready=1 -> out_data 0..9 in order, each 1 cycle after input; no almful asserted.
- out_ready=0 (DEPTH=64, PIPE_DEPTH=4) with a continuous write stream:
  - logb_almful rises the cycle after the 54th write; logb_almful_imme after the 58th.
  - 64 writes are stored, a 65th write sets err_overflow, and the 65th record never appears.
- loge_valid pulses arrive before any begin is read (out_ready=0) -> eout_valid stays 0. Release one begin -> eout_valid rises the next cycle, and exactly one end is emitted.
- Full FIFO with write and out handshake in the same cycle -> write accepted, count stays 64, err_overflow stays 0.
- Assert rst asynchronously between edges with 20 entries and 3 pending ends -> outputs drop at once; after reset, no stale data or ends emerge.

Source files
------------

// File: rtl/axichannel_log_buffer.sv
// Buffers the logger's begin stream in a FWFT FIFO and counts end pulses, re-emitting both
// toward the merger with begin-before-end ordering. Optional stats: AXICHANNEL_LOG_BUFFER_STATS_EN.
module axichannel_log_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int PIPE_DEPTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          logb_valid,
    input  logic [DATA_WIDTH-1:0]         logb_data,
    input  logic                          loge_valid,
    output logic                          logb_almful,
    output logic                          logb_almful_imme,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          eout_valid,
    input  logic                          eout_ready,
    output logic                          err_overflow
`ifdef AXICHANNEL_LOG_BUFFER_STATS_EN
    ,
    output logic [31:0]                   stat_begins,
    output logic [31:0]                   stat_ends,
    output logic [$clog2(DEPTH):0]        stat_max_occ
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_CNT  = PW'(DEPTH);
    localparam logic [PW-1:0] ALMFUL_TH = PW'(DEPTH - (2 * PIPE_DEPTH + 2));
    localparam logic [PW-1:0] IMME_TH   = PW'(DEPTH - (PIPE_DEPTH + 2));

    logic [DATA_WIDTH-1:0] r_ram [DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_almful, r_almful_imme, r_err;
    logic [CNT_WIDTH-1:0]  r_pend_e, r_emitted_gap;

    logic [PW-1:0]         w_count, w_count_next;
    logic [AW-1:0]         w_next_idx;
    logic                  w_full, w_pop, w_push, w_drop;
    logic                  w_nxt_out_valid;
    logic [DATA_WIDTH-1:0] w_nxt_out_data;
    logic                  w_eout_valid, w_eout_hs, w_end_lost, w_end_acc;

    // The output register always mirrors ram[rd_ptr], so count includes the word it holds.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_count        = r_wr_ptr - r_rd_ptr;
        w_full         = (w_count == FULL_CNT);
        w_pop          = r_out_valid && out_ready;
        w_push         = logb_valid && (!w_full || w_pop);
        w_drop         = logb_valid && !w_push;
        w_count_next   = w_count + PW'(w_push) - PW'(w_pop);
        w_next_idx     = r_rd_ptr[AW-1:0] + AW'(1);
        w_nxt_out_valid = (w_count_next != '0);
        w_nxt_out_data = r_out_data;
        if (w_pop) begin
            if (w_count > PW'(1))
                w_nxt_out_data = r_ram[w_next_idx];
            else if (w_push)
                w_nxt_out_data = logb_data;
        end else if (!r_out_valid && w_push) begin
            w_nxt_out_data = logb_data;
        end

        w_eout_valid = (r_pend_e != '0) && (r_emitted_gap != '0);
        w_eout_hs    = w_eout_valid && eout_ready;
        w_end_lost   = loge_valid && (&r_pend_e) && !w_eout_hs;
        w_end_acc    = loge_valid && !w_end_lost;
    end

    // NOTE: the storage array has no reset; only pointers define which words are live.
    always_ff @(posedge clk) begin
        if (w_push)
            r_ram[r_wr_ptr[AW-1:0]] <= logb_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_almful      <= 1'b0;
            r_almful_imme <= 1'b0;
            r_err         <= 1'b0;
            r_pend_e      <= '0;
            r_emitted_gap <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_out_valid   <= w_nxt_out_valid;
            r_out_data    <= w_nxt_out_data;
            r_almful      <= (w_count_next >= ALMFUL_TH);
            r_almful_imme <= (w_count_next >= IMME_TH);
            if (w_drop || w_end_lost) r_err <= 1'b1;
            case ({w_end_acc, w_eout_hs})
                2'b10:   r_pend_e <= r_pend_e + CNT_WIDTH'(1);
                2'b01:   r_pend_e <= r_pend_e - CNT_WIDTH'(1);
                default: r_pend_e <= r_pend_e;
            endcase
            case ({w_pop, w_eout_hs})
                2'b10:   r_emitted_gap <= r_emitted_gap + CNT_WIDTH'(1);
                2'b01:   r_emitted_gap <= r_emitted_gap - CNT_WIDTH'(1);
                default: r_emitted_gap <= r_emitted_gap;
            endcase
        end
    end

    assign out_valid        = r_out_valid;
    assign out_data         = r_out_data;
    assign eout_valid       = w_eout_valid;
    assign logb_almful      = r_almful;
    assign logb_almful_imme = r_almful_imme;
    assign err_overflow     = r_err;

`ifdef AXICHANNEL_LOG_BUFFER_STATS_EN
    logic [31:0] r_stat_begins, r_stat_ends;
    logic [PW-1:0] r_stat_max_occ;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_begins  <= '0;
            r_stat_ends    <= '0;
            r_stat_max_occ <= '0;
        end else begin
            if (w_push)    r_stat_begins <= r_stat_begins + 32'd1;
            if (w_end_acc) r_stat_ends   <= r_stat_ends + 32'd1;
            if (w_count_next > r_stat_max_occ) r_stat_max_occ <= w_count_next;
        end
    end

    assign stat_begins  = r_stat_begins;
    assign stat_ends    = r_stat_ends;
    assign stat_max_occ = r_stat_max_occ;
`endif
endmodule

// File: tb/tb_axichannel_log_buffer.sv
// Scoreboard bench for axichannel_log_buffer: begins are queued when accepted and compared on pop.
module tb_axichannel_log_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int PIPE  = 4;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          logb_valid = 1'b0;
    logic [DW-1:0] logb_data = '0;
    logic          loge_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          eout_ready = 1'b0;
    logic          logb_almful, logb_almful_imme, out_valid, eout_valid, err_overflow;
    logic [DW-1:0] out_data;

    int n_checks = 0;
    int n_pass = 0;
    logic [DW-1:0] exp_q[$];
    int  m_count = 0;
    bit  m_err = 1'b0;
    int  m_pend = 0;
    int  m_gap = 0;
    int  ends_seen = 0;

    always #5 clk = ~clk;

    axichannel_log_buffer #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .PIPE_DEPTH(PIPE), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .logb_valid(logb_valid), .logb_data(logb_data), .loge_valid(loge_valid),
        .logb_almful(logb_almful), .logb_almful_imme(logb_almful_imme),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .eout_valid(eout_valid), .eout_ready(eout_ready), .err_overflow(err_overflow)
    );

    initial begin
        #2000000;
        $display("FAIL timeout: simulation bound reached");
        $fatal(1, "timeout");
    end

    task automatic model_reset();
        exp_q.delete();
        m_count = 0; m_err = 1'b0; m_pend = 0; m_gap = 0;
    endtask

    // One clock of stimulus; outputs compared before the edge, flags compared #1 after it.
    task automatic cycle(input bit bv, input logic [DW-1:0] bd, input bit ev,
                         input bit ordy, input bit erdy);
        bit pop, push, e_v, ehs;
        logic [DW-1:0] exp_d;
        logb_valid = bv; logb_data = bd; loge_valid = ev;
        out_ready = ordy; eout_ready = erdy;
        pop  = (m_count > 0) && ordy;
        push = bv && ((m_count < DEPTH) || pop);
        e_v  = (m_pend != 0) && (m_gap != 0);
        ehs  = e_v && erdy;
        n_checks++;
        if (out_valid !== 1'(m_count > 0))
            $display("FAIL out_valid: got %b expected %b", out_valid, m_count > 0);
        else n_pass++;
        n_checks++;
        if (eout_valid !== e_v)
            $display("FAIL eout_valid: got %b expected %b", eout_valid, e_v);
        else n_pass++;
        if (pop) begin
            exp_d = exp_q.pop_front();
            n_checks++;
            if (out_data !== exp_d)
                $display("FAIL out_data: got %0h expected %0h", out_data, exp_d);
            else n_pass++;
        end
        if (ehs) ends_seen++;
        @(posedge clk); #1;
        if (push) exp_q.push_back(bd);
        if (bv && !push) m_err = 1'b1;
        m_count = m_count + int'(push) - int'(pop);
        if (ev && !ehs) m_pend++;
        else if (!ev && ehs) m_pend--;
        if (pop && !ehs) m_gap++;
        else if (!pop && ehs) m_gap--;
        n_checks++;
        if (logb_almful !== 1'(m_count >= DEPTH - (2 * PIPE + 2)))
            $display("FAIL logb_almful: got %b at count %0d", logb_almful, m_count);
        else n_pass++;
        n_checks++;
        if (logb_almful_imme !== 1'(m_count >= DEPTH - (PIPE + 2)))
            $display("FAIL logb_almful_imme: got %b at count %0d", logb_almful_imme, m_count);
        else n_pass++;
        n_checks++;
        if (err_overflow !== m_err)
            $display("FAIL err_overflow: got %b expected %b", err_overflow, m_err);
        else n_pass++;
    endtask

    task automatic do_reset();
        logb_valid = 1'b0; loge_valid = 1'b0; out_ready = 1'b0; eout_ready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; logb_valid = 1'b1; logb_data = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({out_valid, eout_valid, logb_almful, logb_almful_imme, err_overflow} !== 5'b0 ||
            out_data !== '0)
            $display("FAIL reset_outputs: got v=%b ev=%b af=%b afi=%b err=%b d=%0h expected all 0",
                     out_valid, eout_valid, logb_almful, logb_almful_imme, err_overflow, out_data);
        else n_pass++;
        rst = 1'b0;
        model_reset();
        cycle(1'b1, 32'h0000_00A5, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_00A5)
            $display("FAIL first_write: got v=%b d=%0h expected v=1 d=a5", out_valid, out_data);
        else n_pass++;
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_stream();
        for (int i = 0; i < 10; i++) cycle(1'b1, DW'(i), 1'b0, 1'b1, 1'b0);
        repeat (2) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (exp_q.size() != 0)
            $display("FAIL stream_drain: got %0d left expected 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 65; i++) cycle(1'b1, DW'(100 + i), 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (err_overflow !== 1'b1)
            $display("FAIL overflow_flag: got %b expected 1", err_overflow);
        else n_pass++;
        repeat (66) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0)
            $display("FAIL overflow_drain: got v=%b left=%0d expected v=0 left=0",
                     out_valid, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_end_order();
        do_reset();
        cycle(1'b1, 32'h7, 1'b0, 1'b0, 1'b1);
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 1'b1);
        ends_seen = 0;
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        repeat (4) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (ends_seen != 1)
            $display("FAIL ends_emitted: got %0d expected 1", ends_seen);
        else n_pass++;
    endtask

    task automatic test_full_simul();
        do_reset();
        for (int i = 0; i < 64; i++) cycle(1'b1, DW'(500 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, DW'(999), 1'b0, 1'b1, 1'b0);
        n_checks++;
        if (err_overflow !== 1'b0 || logb_almful_imme !== 1'b1)
            $display("FAIL full_simul: got err=%b afi=%b expected err=0 afi=1",
                     err_overflow, logb_almful_imme);
        else n_pass++;
        repeat (65) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 21; i++) cycle(1'b1, DW'(700 + i), 1'b0, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, eout_valid, logb_almful, logb_almful_imme} !== 4'b0 || out_data !== '0)
            $display("FAIL async_reset: got v=%b ev=%b af=%b afi=%b d=%0h expected all 0",
                     out_valid, eout_valid, logb_almful, logb_almful_imme, out_data);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        ends_seen = 0;
        repeat (5) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (ends_seen != 0)
            $display("FAIL stale_ends: got %0d expected 0", ends_seen);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fill_overflow();
        test_end_order();
        test_full_simul();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
